// File: rtl/g05_pkg.sv
// Shared types and defaults for the Guia 05 equivalence sweeper.
package g05_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned G05_N_IN_DEF   = 2;
  localparam int unsigned G05_SETTLE_DEF = 1;

  // All-ones vector of width n (n <= 8), zero-extended to 8 bits.
  function automatic logic [7:0] vec_last(input int unsigned n);
    logic [8:0] one_hot;
    one_hot  = 9'd1 << n;
    vec_last = 8'(one_hot - 9'd1);
  endfunction

endpackage

// File: rtl/g05_vec_counter.sv
// Stimulus vector counter: clear to zero, step by one, flag the last vector.
module g05_vec_counter
  import g05_pkg::*;
#(
  parameter int unsigned N_IN = G05_N_IN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [N_IN-1:0] count,
  output logic            is_last
);

  localparam logic [7:0] LAST8 = vec_last(N_IN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign is_last = (count == LAST8[N_IN-1:0]);

endmodule

// File: rtl/g05_equiv_sweeper.sv
// Sweeps every input vector through a reference and a gate-level unit and
// records mismatch count, first failing vector and an overall pass flag.
module g05_equiv_sweeper
  import g05_pkg::*;
#(
  parameter int unsigned N_IN   = G05_N_IN_DEF,
  parameter int unsigned SETTLE = G05_SETTLE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            ref_out,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_e     state;
  logic [3:0] settle_cnt;
  logic       vec_clr;
  logic       vec_inc;
  logic       vec_is_last;

  // Counter steps are decoded from the same conditions the FSM uses below.
  always_comb begin
    vec_clr = (state == ST_IDLE) && start;
    vec_inc = (state == ST_SAMPLE) && !abort && !vec_is_last;
  end

  g05_vec_counter #(
    .N_IN(N_IN)
  ) u_vec_counter (
    .clk    (clk),
    .rst    (reset),
    .clr    (vec_clr),
    .inc    (vec_inc),
    .count  (vec),
    .is_last(vec_is_last)
  );

  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      settle_cnt      <= '0;
      busy            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            settle_cnt      <= SETTLE_LD;
            state           <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
            if (settle_cnt <= 4'd1) begin
              state <= ST_SAMPLE;
            end
          end
        end
        ST_SAMPLE: begin
          // abort wins over the compare: the aborted sample is never counted
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (ref_out != dut_out) begin
              err_cnt <= err_cnt + 1'b1;
              if (!first_err_valid) begin
                first_err_vec   <= vec;
                first_err_valid <= 1'b1;
              end
            end
            if (vec_is_last) begin
              state <= ST_DONE;
            end else begin
              settle_cnt <= SETTLE_LD;
              state      <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          pass  <= (err_cnt == '0);
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g05_equiv_sweeper.sv
// Directed bench: two sweeper instances (settle 1 and settle 0) checked against
// a behavioural model of ~x&y and its NAND realisation with injectable faults.
module tb_g05_equiv_sweeper;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_a, abort_a, ref_a, dut_a, busy_a, done_a, pass_a, fvalid_a;
  logic [1:0] vec_a, fvec_a;
  logic [2:0] err_a;
  logic       start_b, abort_b, ref_b, dut_b, busy_b, done_b, pass_b, fvalid_b;
  logic [1:0] vec_b, fvec_b;
  logic [2:0] err_b;

  int mode;  // 0: correct NAND unit, 1: stuck at 0, 2: stuck at 1
  int errors = 0;
  int checks = 0;

  typedef struct {
    int err;
    int fvec;
    int fvalid;
    int pass;
  } exp_t;
  exp_t sbq[$];

  function automatic logic ref_fn(input logic [1:0] v);
    return ~v[1] & v[0];
  endfunction

  function automatic logic nand_fn(input logic [1:0] v);
    logic n1, n2;
    n1 = ~(v[1] & v[1]);
    n2 = ~(n1 & v[0]);
    return ~(n2 & n2);
  endfunction

  function automatic logic dut_fn(input logic [1:0] v, input int m);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    return nand_fn(v);
  endfunction

  function automatic exp_t model(input int m, input int upto);
    exp_t e;
    logic [1:0] vv;
    e = '{0, 0, 0, 0};
    for (int v = 0; v < upto; v++) begin
      vv = 2'(v);
      if (ref_fn(vv) != dut_fn(vv, m)) begin
        if (e.fvalid == 0) begin
          e.fvec   = v;
          e.fvalid = 1;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  assign ref_a = ref_fn(vec_a);
  assign dut_a = dut_fn(vec_a, mode);
  assign ref_b = ref_fn(vec_b);
  assign dut_b = dut_fn(vec_b, mode);

  g05_equiv_sweeper #(.N_IN(2), .SETTLE(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .ref_out(ref_a), .dut_out(dut_a), .vec(vec_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_vec(fvec_a), .first_err_valid(fvalid_a)
  );

  g05_equiv_sweeper #(.N_IN(2), .SETTLE(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .ref_out(ref_b), .dut_out(dut_b), .vec(vec_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_vec(fvec_b), .first_err_valid(fvalid_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic ab);
    if (sel == 0) begin
      start_a = st;
      abort_a = ab;
    end else begin
      start_b = st;
      abort_b = ab;
    end
  endtask

  task automatic sweep(input int sel, input int m, input bit repulse, input bit with_abort);
    int   s;
    int   total;
    int   c;
    int   ev;
    bit   seen;
    exp_t e;
    s     = (sel == 0) ? 1 : 0;
    total = 4 * (s + 1);
    mode  = m;
    sbq.push_back(model(m, 4));
    @(negedge clk);
    drive(sel, 1'b1, with_abort);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0);
    chk("start_err_clr", (sel == 0) ? err_a : err_b, 0);
    chk("start_busy", (sel == 0) ? busy_a : busy_b, 1);
    chk("start_pass_clr", (sel == 0) ? pass_a : pass_b, 0);
    seen = 0;
    c    = 0;
    while (!seen && c <= total + 4) begin
      ev = c / (s + 1);
      if (ev > 3) ev = 3;
      chk("vec_seq", (sel == 0) ? vec_a : vec_b, ev);
      if (((sel == 0) ? done_a : done_b) === 1'b1) begin
        seen = 1;
        chk("done_latency", c, total);
        chk("done_busy", (sel == 0) ? busy_a : busy_b, 1);
        if (sbq.size() == 0) begin
          chk("sb_nonempty", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          chk("err_cnt", (sel == 0) ? err_a : err_b, e.err);
          chk("first_err_valid", (sel == 0) ? fvalid_a : fvalid_b, e.fvalid);
          chk("first_err_vec", (sel == 0) ? fvec_a : fvec_b, e.fvec);
          @(posedge clk);
          #1;
          chk("pass", (sel == 0) ? pass_a : pass_b, e.pass);
          chk("busy_after", (sel == 0) ? busy_a : busy_b, 0);
          chk("done_one_cycle", (sel == 0) ? done_a : done_b, 0);
          chk("vec_hold", (sel == 0) ? vec_a : vec_b, 3);
        end
      end else begin
        if (repulse && c == 1) drive(sel, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0);
        c++;
      end
    end
    if (!seen) chk("done_timeout", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset   = 1'b1;
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    mode    = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", vec_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fvec", fvec_a, 0);
    chk("rst_fvalid", fvalid_a, 0);
    @(negedge clk);
    reset = 1'b0;

    sweep(0, 0, 1'b0, 1'b0);
    sweep(0, 1, 1'b0, 1'b0);
    sweep(0, 2, 1'b0, 1'b0);
    sweep(0, 0, 1'b0, 1'b0);
    sweep(1, 0, 1'b1, 1'b0);
    sweep(1, 2, 1'b0, 1'b0);

    // abort while sampling vec=2 with a stuck-at-1 unit
    mode = 2;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_pre_vec", vec_a, 2);
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    abort_a = 1'b0;
    e = model(2, 2);
    chk("abort_busy", busy_a, 0);
    chk("abort_err", err_a, e.err);
    chk("abort_fvec", fvec_a, e.fvec);
    chk("abort_fvalid", fvalid_a, e.fvalid);
    chk("abort_vec", vec_a, 2);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", done_a, 0);
      chk("abort_idle_busy", busy_a, 0);
      @(posedge clk);
      #1;
    end
    chk("abort_pass", pass_a, 0);

    // asynchronous reset in the middle of a sweep
    mode = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_vec", vec_a, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_vec", vec_a, 0);
    chk("async_busy", busy_a, 0);
    chk("async_done", done_a, 0);
    chk("async_err", err_a, 0);
    chk("async_fvalid", fvalid_a, 0);
    @(negedge clk);
    reset = 1'b0;
    sweep(0, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
